// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the scanned seven-segment display:
// glyph constants, conversion FSM encoding and digit count.
package disp_pkg;

   localparam int DIGITS = 4;

   // Common-anode glyphs, active low: [6:0] = g..a, [7] = dp (1 = off)
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_MINUS = 8'hBF;
   // AND mask that lights the decimal point
   localparam logic [7:0] SEG_DP_ON = 8'h7F;

   // Largest light reading that fits in four decimal digits
   localparam logic [15:0] LIGHT_MAX = 16'd9999;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_COMMIT
   } conv_state_t;

   // BCD digit to glyph; non-decimal codes render blank
   function automatic logic [7:0] seg_glyph(input logic [3:0] digit);
      logic [7:0] g;
      case (digit)
         4'd0:    g = SEG_0;
         4'd1:    g = SEG_1;
         4'd2:    g = SEG_2;
         4'd3:    g = SEG_3;
         4'd4:    g = SEG_4;
         4'd5:    g = SEG_5;
         4'd6:    g = SEG_6;
         4'd7:    g = SEG_7;
         4'd8:    g = SEG_8;
         4'd9:    g = SEG_9;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Display word input and segment/anode outputs of the scanned display.
interface seg_scan_display_if;
   logic [15:0] datain;
   logic        flag;
   logic [7:0]  seg;
   logic [3:0]  an;

   // Data selector side: drives the word, observes the panel
   modport master (output datain, output flag, input seg, input an);
   // Display side: consumes the word, drives the panel
   modport slave  (input datain, input flag, output seg, output an);
endinterface

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential 16-bit double-dabble converter. A start pulse loads bin;
// sixteen shift steps follow. done is high during the final step, so bcd
// is valid from the next cycle until the next start.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        done,
   output logic [15:0] bcd
);

   logic [15:0] bin_reg;
   logic [15:0] bcd_reg;
   logic [3:0]  cnt_reg;
   logic        busy_reg;
   logic [15:0] bcd_adj;

   // Add-3 correction on every BCD nibble that is 5 or more before the shift
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 :
                                     bcd_reg[gi*4 +: 4];
      end
   endgenerate

   // Load on start, then shift one binary bit into the BCD field per cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_reg  <= '0;
         bcd_reg  <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
      end else if (start) begin
         bin_reg  <= bin;
         bcd_reg  <= '0;
         cnt_reg  <= '0;
         busy_reg <= 1'b1;
      end else if (busy_reg) begin
         bcd_reg <= {bcd_adj[14:0], bin_reg[15]};
         bin_reg <= {bin_reg[14:0], 1'b0};
         cnt_reg <= cnt_reg + 4'd1;
         if (cnt_reg == 4'd15) begin
            busy_reg <= 1'b0;
         end
      end
   end

   assign done = busy_reg && (cnt_reg == 4'd15);
   assign bcd  = bcd_reg;

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed seven-segment display. Once per scan frame the
// display word is snapshotted, converted to decimal (signed xx.x temperature
// or unsigned 0..9999 light) and committed atomically to the digit registers.
module seg_scan_display
   import disp_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic               clk,
   input  logic               rst_n,
   seg_scan_display_if.slave  bus
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_reg;
   logic [1:0]       idx_reg;
   logic             frame_start;

   conv_state_t      state_reg;
   logic             start_reg;
   logic [15:0]      snap_data_reg;
   logic             snap_flag_reg;
   logic             neg_reg;
   logic [3:0]       tenths_reg;
   logic [7:0]       disp_reg [DIGITS];
   logic [7:0]       disp_next [DIGITS];

   logic [7:0]       seg_reg;
   logic [3:0]       an_reg;

   logic             snap_neg;
   logic [15:0]      snap_mag;
   logic [7:0]       tenths_prod;
   logic [15:0]      conv_bin;
   logic             conv_done;
   logic [15:0]      conv_bcd;

   // Slot timer and digit index; frame start is the wrap from digit 3 to 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg <= '0;
         idx_reg <= '0;
      end else if (div_reg == DIV_LAST) begin
         div_reg <= '0;
         idx_reg <= idx_reg + 2'd1;
      end else begin
         div_reg <= div_reg + 1'b1;
      end
   end

   assign frame_start = (div_reg == DIV_LAST) && (idx_reg == 2'd3);

   // Sign/magnitude and fractional part from the snapshot; 0x8000 wraps to itself
   always_comb begin
      snap_neg    = snap_data_reg[15];
      snap_mag    = snap_neg ? (~snap_data_reg + 16'd1) : snap_data_reg;
      tenths_prod = {4'd0, snap_mag[3:0]} * 8'd10;
      if (snap_flag_reg) begin
         conv_bin = {9'd0, snap_mag[10:4]};
      end else if (snap_data_reg > LIGHT_MAX) begin
         conv_bin = LIGHT_MAX;
      end else begin
         conv_bin = snap_data_reg;
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_reg),
      .bin   (conv_bin),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // Glyph formatting of the finished conversion, with leading-zero blanking
   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         disp_next[i] = SEG_BLANK;
      end
      if (snap_flag_reg) begin
         if (neg_reg) begin
            disp_next[3] = SEG_MINUS;
         end else if (conv_bcd[11:8] != 4'd0) begin
            disp_next[3] = seg_glyph(conv_bcd[11:8]);
         end
         if ((conv_bcd[11:8] != 4'd0) || (conv_bcd[7:4] != 4'd0)) begin
            disp_next[2] = seg_glyph(conv_bcd[7:4]);
         end
         disp_next[1] = seg_glyph(conv_bcd[3:0]) & SEG_DP_ON;
         disp_next[0] = seg_glyph(tenths_reg);
      end else begin
         if (conv_bcd[15:12] != 4'd0) begin
            disp_next[3] = seg_glyph(conv_bcd[15:12]);
         end
         if (conv_bcd[15:8] != 8'd0) begin
            disp_next[2] = seg_glyph(conv_bcd[11:8]);
         end
         if (conv_bcd[15:4] != 12'd0) begin
            disp_next[1] = seg_glyph(conv_bcd[7:4]);
         end
         disp_next[0] = seg_glyph(conv_bcd[3:0]);
      end
   end

   // Conversion FSM: snapshot at frame start, convert, commit all digits at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         start_reg     <= 1'b0;
         snap_data_reg <= '0;
         snap_flag_reg <= 1'b0;
         neg_reg       <= 1'b0;
         tenths_reg    <= '0;
         for (int i = 0; i < DIGITS; i++) begin
            disp_reg[i] <= SEG_BLANK;
         end
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (frame_start) begin
                  snap_data_reg <= bus.datain;
                  snap_flag_reg <= bus.flag;
                  start_reg     <= 1'b1;
                  state_reg     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               start_reg  <= 1'b0;
               neg_reg    <= snap_neg;
               tenths_reg <= tenths_prod[7:4];
               state_reg  <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (conv_done) begin
                  state_reg <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               for (int i = 0; i < DIGITS; i++) begin
                  disp_reg[i] <= disp_next[i];
               end
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Registered panel drive: one-hot-low anode and the current digit's glyph
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_reg <= SEG_BLANK;
         an_reg  <= 4'b1111;
      end else begin
         seg_reg <= disp_reg[idx_reg];
         an_reg  <= ~(4'b0001 << idx_reg);
      end
   end

   assign bus.seg = seg_reg;
   assign bus.an  = an_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with a 32-cycle digit slot.
module tb_seg_scan_display;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [7:0] cap [4];

   seg_scan_display_if bus ();

   seg_scan_display #(.SCAN_DIV(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report a mismatch
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a given anode pattern, sampling on falling edges
   task automatic wait_an(input logic [3:0] pat);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.an !== pat && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.an !== pat) begin
         check_eq("an_timeout", {28'd0, bus.an}, {28'd0, pat});
      end
   endtask

   // Grab one full frame of glyphs, digit 0 first
   task automatic capture_frame();
      logic [3:0] pat;
      for (int k = 0; k < 4; k++) begin
         pat = ~(4'b0001 << k);
         wait_an(pat);
         repeat (4) @(negedge clk);
         cap[k] = bus.seg;
      end
   endtask

   task automatic check_frame(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                              input logic [7:0] e1, input logic [7:0] e0);
      capture_frame();
      check_eq({tag, "_d3"}, {24'd0, cap[3]}, {24'd0, e3});
      check_eq({tag, "_d2"}, {24'd0, cap[2]}, {24'd0, e2});
      check_eq({tag, "_d1"}, {24'd0, cap[1]}, {24'd0, e1});
      check_eq({tag, "_d0"}, {24'd0, cap[0]}, {24'd0, e0});
      $display("frame %s: seg d3..d0 = %h %h %h %h", tag, cap[3], cap[2], cap[1], cap[0]);
   endtask

   task automatic apply(input logic f, input logic [15:0] d);
      bus.flag   = f;
      bus.datain = d;
      repeat (256) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_an [4];
      exp_an[0] = 4'b1110;
      exp_an[1] = 4'b1101;
      exp_an[2] = 4'b1011;
      exp_an[3] = 4'b0111;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.flag   = 1'b0;
      bus.datain = 16'h0000;

      // 1: reset state, then anode rotation with a blank panel
      repeat (4) @(negedge clk);
      check_eq("rst_seg", {24'd0, bus.seg}, 32'h0000_00FF);
      check_eq("rst_an", {28'd0, bus.an}, 32'h0000_000F);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check_eq("scan_an", {28'd0, bus.an}, {28'd0, exp_an[k]});
         check_eq("scan_seg_blank", {24'd0, bus.seg}, 32'h0000_00FF);
         $display("slot %0d: an=%b seg=%h", k, bus.an, bus.seg);
         repeat (32) @(negedge clk);
      end

      // 2/3: temperature 25.0 and -10.1
      apply(1'b1, 16'h0191);
      check_frame("t_25_0", 8'hFF, 8'hA4, 8'h12, 8'hC0);
      apply(1'b1, 16'hFF5E);
      check_frame("t_m10_1", 8'hBF, 8'hF9, 8'h40, 8'hF9);
      apply(1'b1, 16'h8000);
      check_frame("t_8000", 8'hBF, 8'hFF, 8'h40, 8'hC0);

      // 4: light 1234 and saturation
      apply(1'b0, 16'h04D2);
      check_frame("l_1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
      apply(1'b0, 16'hFFFF);
      check_frame("l_sat", 8'h90, 8'h90, 8'h90, 8'h90);

      // 5: zero, then a mid-frame change must not show until the next frame
      apply(1'b0, 16'h0000);
      check_frame("l_0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
      wait_an(4'b1101);
      bus.datain = 16'h04D2;
      wait_an(4'b1011);
      repeat (4) @(negedge clk);
      check_eq("hold_d2", {24'd0, bus.seg}, 32'h0000_00FF);
      wait_an(4'b0111);
      repeat (4) @(negedge clk);
      check_eq("hold_d3", {24'd0, bus.seg}, 32'h0000_00FF);
      $display("mid-frame change held: d3 seg=%h", bus.seg);
      repeat (256) @(negedge clk);
      check_frame("l_after_hold", 8'hF9, 8'hA4, 8'hB0, 8'h99);

      // 6: reset during SHIFT blanks immediately; recovery afterwards
      bus.flag   = 1'b0;
      bus.datain = 16'h0007;
      wait_an(4'b0111);
      wait_an(4'b1110);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("midrst_seg", {24'd0, bus.seg}, 32'h0000_00FF);
      check_eq("midrst_an", {28'd0, bus.an}, 32'h0000_000F);
      $display("reset in SHIFT: an=%b seg=%h", bus.an, bus.seg);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (256) @(negedge clk);
      check_frame("l_7_recover", 8'hFF, 8'hFF, 8'hFF, 8'hF8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
